// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_pkg
//  Purpose  : Shared CPU/ISA definitions used by the sequential multiplier:
//             data bus width, ALU operation codes and the 2-bit state
//             encodings of the multiply sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package mul_seq_pkg;

    // Width of the word data bus (operands, ALU ports, result).
    localparam int WORD_DATA_W = 32;

    // Width of the ALU operation bus.
    localparam int ALU_OP_W = 4;

    // ALU operation codes understood by the shared ALU.
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'd9;

    // Multiply sequencer state encodings (2 bits).
    localparam logic [1:0] MUL_STATE_IDLE      = 2'd0;
    localparam logic [1:0] MUL_STATE_RUN_ADD   = 2'd1;
    localparam logic [1:0] MUL_STATE_RUN_SHIFT = 2'd2;
    localparam logic [1:0] MUL_STATE_DONE      = 2'd3;

    typedef enum logic [1:0] {
        MUL_IDLE      = MUL_STATE_IDLE,
        MUL_RUN_ADD   = MUL_STATE_RUN_ADD,
        MUL_RUN_SHIFT = MUL_STATE_RUN_SHIFT,
        MUL_DONE      = MUL_STATE_DONE
    } mul_state_e;

    // Addend for one shift-add step: the shifted multiplicand when the
    // current multiplier bit is set, zero otherwise.
    function automatic logic [WORD_DATA_W-1:0] mul_addend(
        input logic                   bit_set,
        input logic [WORD_DATA_W-1:0] multiplicand
    );
        return bit_set ? multiplicand : '0;
    endfunction

endpackage : mul_seq_pkg
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq
//  Purpose  : Shift-and-add 32x32 -> 32 (low word) unsigned multiplier that
//             borrows the CPU's shared ALU. Alternates an add phase and a
//             shift phase per multiplier bit and stops as soon as the
//             remaining multiplier is zero.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [WORD_DATA_W-1:0] i_multiplicand,
    input  logic [WORD_DATA_W-1:0] i_multiplier,
    input  logic [WORD_DATA_W-1:0] i_alu_out,
    output logic [WORD_DATA_W-1:0] o_alu_in0,
    output logic [WORD_DATA_W-1:0] o_alu_in1,
    output logic [ALU_OP_W-1:0]    o_alu_op,
    output logic                   o_alu_own,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [WORD_DATA_W-1:0] o_result
);

    // Shift amount used in the shift phase (one bit per step).
    localparam logic [WORD_DATA_W-1:0] c_SHIFT_ONE = 32'd1;

    mul_state_e             r_state;
    mul_state_e             w_state_next;
    logic [WORD_DATA_W-1:0] r_a;       // multiplicand, shifted left each step
    logic [WORD_DATA_W-1:0] r_b;       // multiplier, shifted right each step
    logic [WORD_DATA_W-1:0] r_acc;     // running partial product
    logic [WORD_DATA_W-1:0] r_result;  // last completed product
    logic                   w_b_zero;

    assign w_b_zero = (r_b == '0);

    // State register; reset overrides everything, including a run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand, accumulator and result registers, advanced per phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                MUL_IDLE, MUL_DONE: begin
                    // Start is only honoured here; while running it is ignored.
                    if (i_start) begin
                        r_a   <= i_multiplicand;
                        r_b   <= i_multiplier;
                        r_acc <= '0;
                    end
                end
                MUL_RUN_ADD: begin
                    // Result only moves on the way into DONE.
                    if (w_b_zero) begin
                        r_result <= r_acc;
                    end else begin
                        r_acc <= i_alu_out;
                    end
                end
                MUL_RUN_SHIFT: begin
                    r_a <= i_alu_out;
                    r_b <= r_b >> 1;
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    // Next-state decode and ALU request / status outputs.
    always_comb begin
        w_state_next = r_state;
        o_alu_op     = ALU_OP_NOP;
        o_alu_in0    = '0;
        o_alu_in1    = '0;
        o_busy       = 1'b0;
        o_done       = 1'b0;

        case (r_state)
            MUL_IDLE: begin
                if (i_start) begin
                    w_state_next = MUL_RUN_ADD;
                end
            end
            MUL_RUN_ADD: begin
                o_busy    = 1'b1;
                o_alu_op  = ALU_OP_ADDU;
                o_alu_in0 = r_acc;
                if (w_b_zero) begin
                    // Nothing left to add; the ALU result is not used.
                    o_alu_in1    = '0;
                    w_state_next = MUL_DONE;
                end else begin
                    o_alu_in1    = mul_addend(r_b[0], r_a);
                    w_state_next = MUL_RUN_SHIFT;
                end
            end
            MUL_RUN_SHIFT: begin
                o_busy       = 1'b1;
                o_alu_op     = ALU_OP_SHLL;
                o_alu_in0    = r_a;
                o_alu_in1    = c_SHIFT_ONE;
                w_state_next = MUL_RUN_ADD;
            end
            MUL_DONE: begin
                o_done = 1'b1;
                // A Start in the DONE cycle chains straight into a new run.
                w_state_next = i_start ? MUL_RUN_ADD : MUL_IDLE;
            end
            default: begin
                w_state_next = MUL_IDLE;
            end
        endcase
    end

    assign o_alu_own = o_busy;
    assign o_result  = r_result;

endmodule : mul_seq
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq
//  Purpose  : Self-checking bench for mul_seq: directed operand table with
//             hand-computed products and latencies, plus hand-written
//             sequences for Start-while-busy, back-to-back chaining and
//             mid-run reset. A phase model checks the ALU request every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq;
    import mul_seq_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [WORD_DATA_W-1:0] mcand;
    logic [WORD_DATA_W-1:0] mplier;
    logic [WORD_DATA_W-1:0] alu_out;
    logic [WORD_DATA_W-1:0] alu_in0;
    logic [WORD_DATA_W-1:0] alu_in1;
    logic [ALU_OP_W-1:0]    alu_op;
    logic                   alu_own;
    logic                   busy;
    logic                   done;
    logic [WORD_DATA_W-1:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .i_alu_out      (alu_out),
        .o_alu_in0      (alu_in0),
        .o_alu_in1      (alu_in1),
        .o_alu_op       (alu_op),
        .o_alu_own      (alu_own),
        .o_busy         (busy),
        .o_done         (done),
        .o_result       (result)
    );

    // Stand-in for the shared ALU; garbage on NOP so misuse shows up.
    always_comb begin
        alu_out = 32'hBAD0_BAD0;
        if (alu_op == ALU_OP_ADDU)      alu_out = alu_in0 + alu_in1;
        else if (alu_op == ALU_OP_SHLL) alu_out = alu_in0 << alu_in1[4:0];
    end

    // Golden phase model.
    logic [1:0]  m_state;
    logic [31:0] m_a, m_b, m_acc, m_res;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= MUL_STATE_IDLE;
            m_a <= '0; m_b <= '0; m_acc <= '0; m_res <= '0;
        end else begin
            case (m_state)
                MUL_STATE_RUN_ADD: begin
                    if (m_b == 0) begin
                        m_res   <= m_acc;
                        m_state <= MUL_STATE_DONE;
                    end else begin
                        m_acc   <= m_acc + (m_b[0] ? m_a : 32'd0);
                        m_state <= MUL_STATE_RUN_SHIFT;
                    end
                end
                MUL_STATE_RUN_SHIFT: begin
                    m_a     <= {m_a[30:0], 1'b0};
                    m_b     <= {1'b0, m_b[31:1]};
                    m_state <= MUL_STATE_RUN_ADD;
                end
                default: begin
                    if (start) begin
                        m_a <= mcand; m_b <= mplier; m_acc <= '0;
                        m_state <= MUL_STATE_RUN_ADD;
                    end else begin
                        m_state <= MUL_STATE_IDLE;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of ALU request, status and result against the model.
    always @(negedge clk) begin : phase_chk
        logic [ALU_OP_W-1:0] e_op;
        logic [31:0]         e_in0, e_in1;
        logic                e_busy, e_done;
        if (chk_en) begin
            e_op   = ALU_OP_NOP;
            e_in0  = '0;
            e_in1  = '0;
            e_busy = (m_state == MUL_STATE_RUN_ADD) || (m_state == MUL_STATE_RUN_SHIFT);
            e_done = (m_state == MUL_STATE_DONE);
            if (m_state == MUL_STATE_RUN_ADD) begin
                e_op  = ALU_OP_ADDU;
                e_in0 = m_acc;
                e_in1 = (m_b != 0 && m_b[0]) ? m_a : 32'd0;
            end else if (m_state == MUL_STATE_RUN_SHIFT) begin
                e_op  = ALU_OP_SHLL;
                e_in0 = m_a;
                e_in1 = 32'd1;
            end
            checks++;
            if (alu_op !== e_op || alu_in0 !== e_in0 || alu_in1 !== e_in1 ||
                busy !== e_busy || alu_own !== busy || done !== e_done || result !== m_res) begin
                errors++;
                $display("FAIL phase t=%0t op=%0h/%0h in0=%h/%h in1=%h/%h busy=%b/%b own=%b done=%b/%b result=%h/%h (actual/required)",
                         $time, alu_op, e_op, alu_in0, e_in0, alu_in1, e_in1,
                         busy, e_busy, alu_own, done, e_done, result, m_res);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle t+1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    // Counts cycles from t+1 until Done; optionally pulses a foreign Start.
    task automatic await_done(input logic [31:0] exp_res, input int exp_lat,
                              input int glitch_n, input string tag);
        int n = 1;
        int busy_cnt = 0;
        while (done !== 1'b1 && n <= 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == glitch_n) begin
                start = 1'b1; mcand = 32'h9; mplier = 32'h9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{32'd3,        32'd5,        32'd15,       8};
        vecs[1] = '{32'h1234,     32'd0,        32'd0,        2};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        66};
        vecs[3] = '{32'd7,        32'd6,        32'd42,       8};
        vecs[4] = '{32'd1,        32'h80000000, 32'h80000000, 66};
        vecs[5] = '{32'h10000,    32'h10000,    32'h0,        36};
        vecs[6] = '{32'd6,        32'd1,        32'd6,        4};
        vecs[7] = '{32'd0,        32'hFF,       32'd0,        18};
        vecs[8] = '{32'hDEAD,     32'h10,       32'hDEAD0,    12};

        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_done",   32'(done),    32'd0);
        check("rst_own",    32'(alu_own), 32'd0);
        check("rst_result", result,       32'd0);
        check("rst_aluop",  32'(alu_op),  32'(ALU_OP_NOP));
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].a, vecs[i].b);
            await_done(vecs[i].res, vecs[i].lat, 0, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Start while busy is ignored, then chain a new op from the DONE cycle.
        launch(32'd3, 32'd5);
        await_done(32'd15, 8, 3, "busy_start");
        launch(32'd7, 32'd6);
        await_done(32'd42, 8, 0, "chained");
        @(negedge clk);
        check("chained_done_pulse", 32'(done), 32'd0);

        // Reset in cycle t+5 of a 3*5 run.
        launch(32'd3, 32'd5);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", result,      32'd0);
        begin
            int pulses = 0;
            repeat (12) begin
                @(negedge clk);
                if (done === 1'b1) pulses++;
            end
            check("midrst_no_done", 32'(pulses), 32'd0);
        end
        launch(32'd7, 32'd6);
        await_done(32'd42, 8, 0, "after_rst");
        @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul_seq
`default_nettype wire
